// File: rtl/mem_access_pkg.sv
// Shared constants, memory request payload and funct3 decode helpers for mem_access_unit.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] BHW_NONE = 3'b000;
  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_WORD = 3'b100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_MISALIGN = 2'd3;

  typedef struct packed {
    logic              wr_nrd;
    logic [2:0]        bhw;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [2:0] f3_bhw(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return BHW_BYTE;
      2'b01:   return BHW_HALF;
      default: return BHW_WORD;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of raw memory read data according to the load funct3.
module load_extender
  import mem_access_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] raw_i,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = raw_i;
    case (funct3_i)
      F3_B:    ext_c = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_c = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_c = {24'b0, raw_i[7:0]};
      F3_HU:   ext_c = {16'b0, raw_i[15:0]};
      default: ext_c = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one request to main memory, extends load data, reports faults.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              mem_request,
  output logic [2:0]        mem_bhw,
  output logic              mem_WR_nRD,
  output logic [ADDR_W-1:0] mem_ADR,
  output logic [DATA_W-1:0] mem_DATA,
  input  logic [DATA_W-1:0] mem_DATAOUT,
  input  logic              mem_send
);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_cause_q, pend_cause_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] ext_data;
  logic              misalign;

`ifdef MISALIGN_TRAP_EN
  assign misalign = f3_misaligned(funct3, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  load_extender u_load_extender (
    .funct3_i (f3_q),
    .raw_i    (mem_DATAOUT),
    .ext_c    (ext_data)
  );

  // Dropped on the completion edge so memory never sees a second request.
  assign mem_request = (state_q == ST_REQ) & ~mem_send;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    cause_d      = cause_q;
    pend_d       = pend_q;
    pend_cause_d = pend_cause_q;
    req_d        = req_q;
    case (state_q)
      ST_IDLE: begin
        // Rejected accesses report one edge after acceptance without touching memory.
        if (pend_q) begin
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = pend_cause_q;
          rdata_d = '0;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (start) begin
          busy_d = 1'b1;
          f3_d   = funct3;
          if (!f3_legal(is_store, funct3)) begin
            pend_d       = 1'b1;
            pend_cause_d = FC_ILLEGAL;
          end else if (misalign) begin
            pend_d       = 1'b1;
            pend_cause_d = FC_MISALIGN;
          end else begin
            state_d      = ST_REQ;
            cnt_d        = '0;
            req_d.wr_nrd = is_store;
            req_d.bhw    = f3_bhw(funct3);
            req_d.adr    = addr;
            req_d.data   = wdata;
          end
        end
      end
      ST_REQ: begin
        if (mem_send) begin
          done_d  = 1'b1;
          fault_d = 1'b0;
          cause_d = FC_NONE;
          rdata_d = req_q.wr_nrd ? '0 : ext_data;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
          rdata_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      cause_q      <= FC_NONE;
      pend_q       <= 1'b0;
      pend_cause_q <= FC_NONE;
      req_q        <= '{wr_nrd: 1'b0, bhw: BHW_NONE, adr: '0, data: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      pend_q       <= pend_d;
      pend_cause_q <= pend_cause_d;
      req_q        <= req_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign mem_bhw     = req_q.bhw;
  assign mem_WR_nRD  = req_q.wr_nrd;
  assign mem_ADR     = req_q.adr;
  assign mem_DATA    = req_q.data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: per-cycle expectations from a byte-array memory model.
module tb_mem_access_unit;

  localparam int TO   = 16;
  localparam int MAXC = 8192;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        busy, done, fault, mem_request, mem_WR_nRD;
  logic [31:0] rdata, mem_ADR, mem_DATA;
  logic [1:0]  fault_cause;
  logic [2:0]  mem_bhw;
  logic [31:0] mem_DATAOUT = 32'b0;
  logic        mem_send = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause), .mem_request(mem_request),
    .mem_bhw(mem_bhw), .mem_WR_nRD(mem_WR_nRD), .mem_ADR(mem_ADR),
    .mem_DATA(mem_DATA), .mem_DATAOUT(mem_DATAOUT), .mem_send(mem_send)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Expected outputs indexed by absolute cycle number.
  bit          e_done [MAXC];
  bit          e_busy [MAXC];
  bit          e_req  [MAXC];
  bit          e_fault[MAXC];
  bit          e_wr   [MAXC];
  logic [1:0]  e_cause[MAXC];
  logic [2:0]  e_bhw  [MAXC];
  logic [31:0] e_rdata[MAXC];
  logic [31:0] e_adr  [MAXC];
  logic [31:0] e_data [MAXC];
  logic [7:0]  mem    [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++) v = v + (longint'(mem[8'(a + 32'(i))]) << (8 * i));
    if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[8'(a)]};
  endfunction

  always @(negedge CLK) begin
    if (checking && cyc < MAXC) begin
      chk("done", 32'(done), 32'(e_done[cyc]));
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("mem_request", 32'(mem_request), 32'(e_req[cyc]));
      if (e_done[cyc]) begin
        chk("rdata", rdata, e_rdata[cyc]);
        chk("fault", 32'(fault), 32'(e_fault[cyc]));
        chk("fault_cause", 32'(fault_cause), 32'(e_cause[cyc]));
      end
      if (e_req[cyc]) begin
        chk("mem_ADR", mem_ADR, e_adr[cyc]);
        chk("mem_bhw", 32'(mem_bhw), 32'(e_bhw[cyc]));
        chk("mem_WR_nRD", 32'(mem_WR_nRD), 32'(e_wr[cyc]));
        chk("mem_DATA", mem_DATA, e_data[cyc]);
      end
    end
  end

  task automatic scramble_inputs();
    is_store = 1'($urandom);
    funct3   = 3'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    mem_DATAOUT = $urandom;
  endtask

  // Called one step after an edge; returns one step after the edge that raises done.
  // d = cycles of mem_request before mem_send, d < 0 = memory never answers.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int d);
    int c, n, done_c, reqn;
    bit bad;
    logic [1:0] cause;
    c = cyc;
    n = size_of(f3);
    bad = 1'b0;
    cause = 2'd0;
    if (!legal(st, f3)) begin
      bad = 1'b1;
      cause = 2'd1;
    end
`ifdef MISALIGN_TRAP_EN
    else if ((a & 32'(n - 1)) != 32'd0) begin
      bad = 1'b1;
      cause = 2'd3;
    end
`endif
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_send = 1'b0;
    if (bad) begin
      done_c = c + 2;
      e_busy[c + 1] = 1'b1;
      e_done[done_c] = 1'b1; e_fault[done_c] = 1'b1;
      e_cause[done_c] = cause; e_rdata[done_c] = 32'd0;
      @(posedge CLK); #1;
      start = 1'b0; scramble_inputs();
      @(posedge CLK); #1;
    end else begin
      reqn   = (d < 0) ? TO : d;
      done_c = (d < 0) ? c + 1 + TO : c + 2 + d;
      for (int i = c + 1; i < done_c; i++) e_busy[i] = 1'b1;
      for (int i = c + 1; i <= c + reqn; i++) begin
        e_req[i] = 1'b1; e_adr[i] = a; e_bhw[i] = 3'(n); e_wr[i] = st; e_data[i] = wd;
      end
      e_done[done_c]  = 1'b1;
      e_fault[done_c] = (d < 0);
      e_cause[done_c] = (d < 0) ? 2'd2 : 2'd0;
      e_rdata[done_c] = (d < 0 || st) ? 32'd0 : model_load(f3, a);
      @(posedge CLK); #1;
      start = 1'b0; scramble_inputs();
      if (d < 0) begin
        repeat (TO) begin @(posedge CLK); #1; end
      end else begin
        repeat (d) begin @(posedge CLK); #1; end
        mem_send = 1'b1;
        mem_DATAOUT = mem_word(a);
        if (st) for (int i = 0; i < n; i++) mem[8'(a + 32'(i))] = wd[8 * i +: 8];
        @(posedge CLK); #1;
        mem_send = 1'b0;
        mem_DATAOUT = $urandom;
      end
    end
  endtask

  // Idle cycles with stray mem_send pulses that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      scramble_inputs();
      mem_send = ($urandom_range(0, 3) == 0);
      @(posedge CLK); #1;
    end
    mem_send = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst fault_cause", 32'(fault_cause), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst mem_request", 32'(mem_request), 32'd0);
    chk("rst mem_bhw", 32'(mem_bhw), 32'd0);
    chk("rst mem_WR_nRD", 32'(mem_WR_nRD), 32'd0);
    chk("rst mem_ADR", mem_ADR, 32'd0);
    chk("rst mem_DATA", mem_DATA, 32'd0);
  endtask

  initial begin
    #(MAXC * 10 - 50);
    $display("FAIL watchdog: run did not complete in time at cycle %0d", cyc);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, st, r, d, gap;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[16] = 8'hF0; mem[17] = 8'h00; mem[18] = 8'h00; mem[19] = 8'h80;

    #1 nRST = 1'b0;
    #1 chk_reset_outputs();
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    checking = 1'b1;

    access(1'b0, 3'b000, 32'h10, $urandom, 1);
    chk("LB 0x10", rdata, 32'hFFFFFFF0);
    access(1'b0, 3'b100, 32'h10, $urandom, 1);
    chk("LBU 0x10", rdata, 32'h000000F0);
    access(1'b0, 3'b010, 32'h10, $urandom, 1);
    chk("LW 0x10", rdata, 32'h800000F0);

    access(1'b1, 3'b010, 32'h20, 32'h12345678, 1);
    access(1'b1, 3'b000, 32'h21, 32'hCDEF01AB, 2);
    access(1'b0, 3'b010, 32'h20, 32'h0, 1);
    chk("LW after SB", rdata, 32'h1234AB78);

    access(1'b0, 3'b010, 32'h30, 32'h0, -1);
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout cause", 32'(fault_cause), 32'd2);
    idle(2);

    access(1'b0, 3'b011, 32'h34, 32'h0, 1);
    chk("illegal load cause", 32'(fault_cause), 32'd1);
    access(1'b1, 3'b100, 32'h38, 32'h0, 1);
    chk("illegal store cause", 32'(fault_cause), 32'd1);

    access(1'b0, 3'b010, 32'h22, 32'h0, 1);
`ifdef MISALIGN_TRAP_EN
    chk("misalign cause", 32'(fault_cause), 32'd3);
`else
    chk("misaligned LW data", rdata, 32'h00001234);
`endif

    // Reset asserted while a request is outstanding.
    c = cyc;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
    for (int i = c + 1; i <= c + 2; i++) begin
      e_busy[i] = 1'b1; e_req[i] = 1'b1; e_adr[i] = 32'h40; e_bhw[i] = 3'b100;
      e_wr[i] = 1'b0; e_data[i] = 32'h0;
    end
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    for (int i = cyc; i < cyc + 40; i++) begin
      e_done[i] = 1'b0; e_busy[i] = 1'b0; e_req[i] = 1'b0;
    end
    #1 chk_reset_outputs();
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    mem_send = 1'b1; mem_DATAOUT = $urandom;
    @(posedge CLK); #1;
    mem_send = 1'b0;
    idle(2);

    for (int t = 0; t < 150; t++) begin
      st = int'($urandom_range(0, 1));
      f3 = 3'($urandom);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
      r  = int'($urandom_range(0, 19));
      d  = (r == 0) ? -1 : r % 5;
      access(st[0], f3, a, $urandom, d);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
